redirect_ctrl: RTL and testbench

Front-end redirect controller for the fetch stage. Arbitrates PC-redirect requests from WB, EX, ID and PRIV (IF1 fifo) and holds the winner until the instruction cache can cancel. Issues one `set_pc` pulse to IF0 and per-stage flush pulses, and tracks in-flight fetches so that stale ICache responses are dropped after a redirect.

---
 rtl/redirect_ctrl_pkg.sv | 35 +++
 rtl/redirect_ctrl_if.sv | 49 ++++
 rtl/redirect_ctrl_fetch_inflight_cnt.sv | 50 +++++
 rtl/redirect_ctrl.sv | 116 +++++++++++
 tb/tb_redirect_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/redirect_ctrl_pkg.sv
// redirect_ctrl shared definitions
// source encodings, flush masks, fsm states
package redirect_ctrl_pkg;

  typedef logic [1:0] src_t;

  localparam src_t SRC_PRIV = 2'd0;
  localparam src_t SRC_ID   = 2'd1;
  localparam src_t SRC_EX   = 2'd2;
  localparam src_t SRC_WB   = 2'd3;

  // mask bit order: {ex, id, if1, if0}
  localparam logic [3:0] FLUSH_WB   = 4'b1111;
  localparam logic [3:0] FLUSH_EX   = 4'b0111;
  localparam logic [3:0] FLUSH_ID   = 4'b0011;
  localparam logic [3:0] FLUSH_PRIV = 4'b0011;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } rd_state_t;

  function automatic logic [3:0] flush_mask(src_t s);
    logic [3:0] m;
    m = FLUSH_PRIV;
    unique case (s)
      SRC_WB:  m = FLUSH_WB;
      SRC_EX:  m = FLUSH_EX;
      SRC_ID:  m = FLUSH_ID;
      default: m = FLUSH_PRIV;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/redirect_ctrl_if.sv
// redirect_ctrl bus bundle
// requests and fetch events in, redirect/flush/drop out
interface redirect_ctrl_if #(
  parameter int EPOCH_W = 2
);
  logic               req_wb;
  logic               req_ex;
  logic               req_id;
  logic               req_priv;
  logic [31:0]        pc_wb;
  logic [31:0]        pc_ex;
  logic [31:0]        pc_id;
  logic [31:0]        pc_priv;
  logic               cancel_ok;
  logic               fetch_req_fire;
  logic               fetch_resp_valid;
  logic               set_pc;
  logic [31:0]        pc_target;
  logic               flush_if0;
  logic               flush_if1;
  logic               flush_id;
  logic               flush_ex;
  logic               resp_drop;
  logic               fetch_stall;
  logic [EPOCH_W-1:0] epoch;

  modport master (
    output req_wb, req_ex, req_id, req_priv,
    output pc_wb, pc_ex, pc_id, pc_priv,
    output cancel_ok, fetch_req_fire,
    output fetch_resp_valid,
    input  set_pc, pc_target,
    input  flush_if0, flush_if1,
    input  flush_id, flush_ex,
    input  resp_drop, fetch_stall, epoch
  );

  modport slave (
    input  req_wb, req_ex, req_id, req_priv,
    input  pc_wb, pc_ex, pc_id, pc_priv,
    input  cancel_ok, fetch_req_fire,
    input  fetch_resp_valid,
    output set_pc, pc_target,
    output flush_if0, flush_if1,
    output flush_id, flush_ex,
    output resp_drop, fetch_stall, epoch
  );

endinterface

// File: rtl/redirect_ctrl_fetch_inflight_cnt.sv
// fetch_inflight_cnt: outstanding and stale
// icache response tracking for redirect_ctrl
module fetch_inflight_cnt #(
  parameter int MAX_OUT = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_fire,
  input  logic i_resp,
  input  logic i_redirect_now,
  input  logic i_pending,
  output logic o_resp_drop,
  output logic o_stall
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] W_MAX = CW'(MAX_OUT);

  logic [CW-1:0] r_out;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] w_out_nxt;

  // saturating up/down count of in-flight fetches
  always_comb begin
    w_out_nxt = r_out;
    if (i_fire && !i_resp && r_out != W_MAX)
      w_out_nxt = r_out + CW'(1);
    else if (!i_fire && i_resp && r_out != '0)
      w_out_nxt = r_out - CW'(1);
  end

  assign o_resp_drop = i_resp &&
                       (i_pending || r_drop != '0);
  assign o_stall = (r_out == W_MAX);

  // on redirect every still-open fetch is stale
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out  <= '0;
      r_drop <= '0;
    end else begin
      r_out <= w_out_nxt;
      if (i_redirect_now)
        r_drop <= w_out_nxt;
      else if (o_resp_drop && r_drop != '0)
        r_drop <= r_drop - CW'(1);
    end
  end

endmodule

// File: rtl/redirect_ctrl.sv
// redirect_ctrl: fetch-stage redirect arbiter
// holds winner until icache cancel, then set_pc
module redirect_ctrl
  import redirect_ctrl_pkg::*;
#(
  parameter int MAX_OUT = 4,
  parameter int EPOCH_W = 2
) (
  input logic clk,
  input logic rstn,
  redirect_ctrl_if.slave bus
);

  rd_state_t          r_state;
  rd_state_t          w_state_nxt;
  src_t               r_src;
  src_t               w_src_nxt;
  logic [31:0]        r_pc;
  logic [31:0]        w_pc_nxt;
  logic [EPOCH_W-1:0] r_epoch;
  logic               w_any;
  src_t               w_req_src;
  logic [31:0]        w_req_pc;
  logic               w_set_pc;
  logic [3:0]         w_flush;

  // fixed-priority pick among this cycle's requests
  always_comb begin
    w_any     = bus.req_wb | bus.req_ex |
                bus.req_id | bus.req_priv;
    w_req_src = SRC_PRIV;
    w_req_pc  = bus.pc_priv;
    if (bus.req_wb) begin
      w_req_src = SRC_WB;
      w_req_pc  = bus.pc_wb;
    end else if (bus.req_ex) begin
      w_req_src = SRC_EX;
      w_req_pc  = bus.pc_ex;
    end else if (bus.req_id) begin
      w_req_src = SRC_ID;
      w_req_pc  = bus.pc_id;
    end
  end

  // next state, pending entry and redirect pulse
  always_comb begin
    w_state_nxt = r_state;
    w_src_nxt   = r_src;
    w_pc_nxt    = r_pc;
    w_set_pc    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_WAIT;
          w_src_nxt   = w_req_src;
          w_pc_nxt    = w_req_pc;
        end
      end
      S_WAIT: begin
        if (bus.cancel_ok) begin
          w_set_pc = 1'b1;
          if (w_any) begin
            w_src_nxt = w_req_src;
            w_pc_nxt  = w_req_pc;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (w_any && w_req_src >= r_src) begin
          w_src_nxt = w_req_src;
          w_pc_nxt  = w_req_pc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_flush = w_set_pc ? flush_mask(r_src) : 4'b0;

  assign bus.set_pc    = w_set_pc;
  assign bus.pc_target = w_set_pc ? r_pc : 32'h0;
  assign bus.flush_if0 = w_flush[0];
  assign bus.flush_if1 = w_flush[1];
  assign bus.flush_id  = w_flush[2];
  assign bus.flush_ex  = w_flush[3];
  assign bus.epoch     = r_epoch;

  // pending redirect and fetch epoch
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_src   <= SRC_PRIV;
      r_pc    <= 32'h0;
      r_epoch <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_src   <= w_src_nxt;
      r_pc    <= w_pc_nxt;
      if (w_set_pc)
        r_epoch <= r_epoch + EPOCH_W'(1);
    end
  end

  fetch_inflight_cnt #(
    .MAX_OUT (MAX_OUT)
  ) u_cnt (
    .clk            (clk),
    .rstn           (rstn),
    .i_fire         (bus.fetch_req_fire),
    .i_resp         (bus.fetch_resp_valid),
    .i_redirect_now (w_set_pc),
    .i_pending      (r_state == S_WAIT),
    .o_resp_drop    (bus.resp_drop),
    .o_stall        (bus.fetch_stall)
  );

endmodule

// File: tb/tb_redirect_ctrl.sv
// tb_redirect_ctrl: directed vectors
// with hand-computed expected values
module tb_redirect_ctrl;

  logic clk;
  logic rstn;
  int   n_tot;
  int   n_bad;

  redirect_ctrl_if #(.EPOCH_W(2)) bus();

  redirect_ctrl #(
    .MAX_OUT (4),
    .EPOCH_W (2)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr();
    bus.req_wb = 0;
    bus.req_ex = 0;
    bus.req_id = 0;
    bus.req_priv = 0;
    bus.pc_wb = 0;
    bus.pc_ex = 0;
    bus.pc_id = 0;
    bus.pc_priv = 0;
    bus.cancel_ok = 0;
    bus.fetch_req_fire = 0;
    bus.fetch_resp_valid = 0;
  endtask

  // advance to just after the next edge, idle inputs
  task automatic nxt();
    @(posedge clk);
    #1;
    clr();
  endtask

  function automatic logic [3:0] fl();
    return {bus.flush_ex, bus.flush_id,
            bus.flush_if1, bus.flush_if0};
  endfunction

  task automatic chk_rst(input string tag);
    chk({tag, ".set_pc"}, bus.set_pc, 0);
    chk({tag, ".pc"}, bus.pc_target, 0);
    chk({tag, ".flush"}, fl(), 0);
    chk({tag, ".epoch"}, bus.epoch, 0);
    chk({tag, ".drop"}, bus.resp_drop, 0);
    chk({tag, ".stall"}, bus.fetch_stall, 0);
  endtask

  // one redirect from a source, checked on the pulse
  task automatic redir_priv(input logic [31:0] pc,
                            input logic [1:0] ep);
    bus.req_priv = 1;
    bus.pc_priv = pc;
    nxt();
    bus.cancel_ok = 1;
    #1;
    chk("ep.set_pc", bus.set_pc, 1);
    chk("ep.pc", bus.pc_target, pc);
    chk("ep.flush", fl(), 4'b0011);
    nxt();
    #1;
    chk("ep.epoch", bus.epoch, ep);
  endtask

  initial begin
    logic [1:0] eps [5];
    n_tot = 0;
    n_bad = 0;
    clr();
    rstn = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_rst("rst");
    rstn = 1;
    nxt();

    // single EX redirect
    bus.req_ex = 1;
    bus.pc_ex = 32'h1C000100;
    bus.cancel_ok = 1;
    #1;
    chk("t1.idle_set_pc", bus.set_pc, 0);
    nxt();
    bus.cancel_ok = 1;
    #1;
    chk("t1.set_pc", bus.set_pc, 1);
    chk("t1.pc", bus.pc_target, 32'h1C000100);
    chk("t1.flush", fl(), 4'b0111);
    chk("t1.epoch0", bus.epoch, 0);
    nxt();
    bus.cancel_ok = 1;
    #1;
    chk("t1.one_pulse", bus.set_pc, 0);
    chk("t1.epoch1", bus.epoch, 1);
    nxt();

    // simultaneous ID and WB: WB wins
    bus.req_id = 1;
    bus.pc_id = 32'h100;
    bus.req_wb = 1;
    bus.pc_wb = 32'h200;
    nxt();
    bus.cancel_ok = 1;
    #1;
    chk("t2.set_pc", bus.set_pc, 1);
    chk("t2.pc", bus.pc_target, 32'h200);
    chk("t2.flush", fl(), 4'b1111);
    nxt();

    // held WAIT, higher replaces, lower ignored
    bus.req_id = 1;
    bus.pc_id = 32'h300;
    nxt();
    #1;
    chk("t3.hold1", bus.set_pc, 0);
    bus.req_ex = 1;
    bus.pc_ex = 32'h400;
    #1;
    chk("t3.hold2", bus.set_pc, 0);
    nxt();
    bus.req_priv = 1;
    bus.pc_priv = 32'h500;
    #1;
    chk("t3.hold3", bus.set_pc, 0);
    nxt();
    bus.cancel_ok = 1;
    #1;
    chk("t3.set_pc", bus.set_pc, 1);
    chk("t3.pc", bus.pc_target, 32'h400);
    chk("t3.flush", fl(), 4'b0111);
    nxt();
    bus.cancel_ok = 1;
    #1;
    chk("t3.no_second", bus.set_pc, 0);
    chk("t3.epoch", bus.epoch, 3);
    nxt();

    // request during set_pc is captured anyway
    bus.req_wb = 1;
    bus.pc_wb = 32'h600;
    nxt();
    bus.cancel_ok = 1;
    bus.req_priv = 1;
    bus.pc_priv = 32'h700;
    #1;
    chk("t3b.pc_a", bus.pc_target, 32'h600);
    nxt();
    bus.cancel_ok = 1;
    #1;
    chk("t3b.set_pc_b", bus.set_pc, 1);
    chk("t3b.pc_b", bus.pc_target, 32'h700);
    chk("t3b.flush_b", fl(), 4'b0011);
    nxt();
    #1;
    chk("t3b.epoch_wrap", bus.epoch, 1);

    // stale responses after redirect with fire
    repeat (3) begin
      bus.fetch_req_fire = 1;
      nxt();
    end
    bus.req_ex = 1;
    bus.pc_ex = 32'h800;
    #1;
    chk("t4.stall3", bus.fetch_stall, 0);
    nxt();
    bus.cancel_ok = 1;
    bus.fetch_req_fire = 1;
    #1;
    chk("t4.set_pc", bus.set_pc, 1);
    nxt();
    #1;
    chk("t4.stall4", bus.fetch_stall, 1);
    for (int i = 0; i < 4; i++) begin
      bus.fetch_resp_valid = 1;
      #1;
      chk($sformatf("t4.drop%0d", i),
          bus.resp_drop, 1);
      nxt();
    end
    bus.fetch_req_fire = 1;
    nxt();
    bus.fetch_resp_valid = 1;
    #1;
    chk("t4.keep", bus.resp_drop, 0);
    nxt();

    // stall at MAX_OUT, released by one response
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t5.nostall%0d", i),
          bus.fetch_stall, 0);
      bus.fetch_req_fire = 1;
      nxt();
    end
    #1;
    chk("t5.stall", bus.fetch_stall, 1);
    bus.fetch_resp_valid = 1;
    #1;
    chk("t5.resp_keep", bus.resp_drop, 0);
    nxt();
    #1;
    chk("t5.unstall", bus.fetch_stall, 0);
    repeat (3) begin
      bus.fetch_resp_valid = 1;
      nxt();
    end

    // epoch sequence from reset
    rstn = 0;
    #1;
    rstn = 1;
    nxt();
    eps[0] = 2'd1;
    eps[1] = 2'd2;
    eps[2] = 2'd3;
    eps[3] = 2'd0;
    eps[4] = 2'd1;
    for (int i = 0; i < 5; i++)
      redir_priv(32'h1000 + 32'(i), eps[i]);

    // reset while a redirect is pending
    repeat (4) begin
      bus.fetch_req_fire = 1;
      nxt();
    end
    bus.req_wb = 1;
    bus.pc_wb = 32'h900;
    nxt();
    #1;
    chk("t6.pre_stall", bus.fetch_stall, 1);
    bus.cancel_ok = 1;
    bus.fetch_resp_valid = 1;
    rstn = 0;
    #1;
    chk_rst("t6.rst");
    nxt();
    bus.cancel_ok = 1;
    #1;
    chk("t6.rst_hold", bus.set_pc, 0);
    rstn = 1;
    nxt();
    bus.cancel_ok = 1;
    #1;
    chk("t6.after", bus.set_pc, 0);
    chk("t6.after_ep", bus.epoch, 0);
    nxt();

    $display("test done: total=%0d bad=%0d",
             n_tot, n_bad);
    $finish;
  end

endmodule
